// File: rtl/gmii_arb_pkg.sv
// Shared definitions for the two-channel GMII transmit arbiter: state encoding,
// parameter defaults and a counter-width helper.
package gmii_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_GRANT = GRANT,
    S_BUSY  = BUSY,
    S_GAP   = GAP
  } arb_state_e;

  localparam int PEND_W_DEF  = 4;
  localparam int GAP_CYC_DEF = 8;
  localparam int TMO_CYC_DEF = 1024;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gmii_arb_pend.sv
// Saturating up/down count of complete lines waiting in one channel's FIFO.
module gmii_arb_pend #(
  parameter int W = 4
) (
  input  logic         tx_clk,
  input  logic         sys_rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/gmii_tx_arb.sv
// Round-robin, frame-granular arbiter sharing one GMII transmitter between two
// line FIFOs. Define GMII_ARB_TIMEOUT_EN to enable the grant watchdog.
module gmii_tx_arb
  import gmii_arb_pkg::*;
#(
  parameter int PEND_W  = PEND_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              tx_clk,
  input  logic              sys_rst_n,
  input  logic              line_done0,
  input  logic              line_done1,
  input  logic              empty0,
  input  logic              empty1,
  input  logic [47:0]       dout0,
  input  logic [47:0]       dout1,
  output logic              rd_en0,
  output logic              rd_en1,
  input  logic              tx_rd_en,
  input  logic              tx_en,
  output logic [47:0]       tx_dout,
  output logic              tx_empty,
  output logic              tx_send,
  output logic              tx_id,
  output logic [PEND_W-1:0] pend0,
  output logic [PEND_W-1:0] pend1,
  output logic              ovf,
  output logic              tmo
);

  localparam int GAP_W = cnt_w(GAP_CYC);

  if (PEND_W < 1 || GAP_CYC < 0 || TMO_CYC < 1) begin : g_param_chk
    $error("gmii_tx_arb: illegal parameter value");
  end

  arb_state_e       state, state_nxt;
  logic             send_nxt, id_nxt;
  logic             last_id, last_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             tx_en_d;
  logic             tx_rise, tx_fall;
  logic             elig0, elig1;
  logic             pick;
  logic             active;
  logic             frame_end;
  logic             sat0, sat1;
  logic             tmo_hit;

  assign tx_rise   = tx_en & ~tx_en_d;
  assign tx_fall   = ~tx_en & tx_en_d;
  assign elig0     = (pend0 != '0) & ~empty0;
  assign elig1     = (pend1 != '0) & ~empty1;
  assign active    = (state == S_GRANT) || (state == S_BUSY);
  assign frame_end = (state == S_BUSY) & tx_fall;

  // Transmitter-facing mux; the idle channel never sees a read strobe.
  assign tx_dout  = tx_id ? dout1 : dout0;
  assign tx_empty = active ? (tx_id ? empty1 : empty0) : 1'b1;
  assign rd_en0   = tx_rd_en & ~tx_id & active;
  assign rd_en1   = tx_rd_en &  tx_id & active;

  gmii_arb_pend #(.W(PEND_W)) u_pend0 (
    .tx_clk    (tx_clk),
    .sys_rst_n (sys_rst_n),
    .inc       (line_done0),
    .dec       (frame_end & ~tx_id),
    .count     (pend0),
    .sat       (sat0)
  );

  gmii_arb_pend #(.W(PEND_W)) u_pend1 (
    .tx_clk    (tx_clk),
    .sys_rst_n (sys_rst_n),
    .inc       (line_done1),
    .dec       (frame_end & tx_id),
    .count     (pend1),
    .sat       (sat1)
  );

`ifdef GMII_ARB_TIMEOUT_EN
  localparam int TMO_W = cnt_w(TMO_CYC);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == S_GRANT) & ~tx_rise & (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else begin
      tmo_cnt <= (state_nxt == S_GRANT) && (state == S_GRANT) ? tmo_cnt + TMO_W'(1) : '0;
      tmo     <= tmo | tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    send_nxt  = tx_send;
    id_nxt    = tx_id;
    last_nxt  = last_id;
    gap_nxt   = gap_cnt;
    pick      = 1'b0;
    case (state)
      S_IDLE: begin
        if (elig0 | elig1) begin
          // With both ready, the channel that did not go last wins.
          pick      = (elig0 & elig1) ? ~last_id : elig1;
          id_nxt    = pick;
          last_nxt  = pick;
          send_nxt  = 1'b1;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (tx_rise) begin
          send_nxt  = 1'b0;
          state_nxt = S_BUSY;
        end else if (tmo_hit) begin
          send_nxt  = 1'b0;
          last_nxt  = tx_id;
          gap_nxt   = GAP_W'(GAP_CYC);
          state_nxt = S_GAP;
        end
      end
      S_BUSY: begin
        if (tx_fall) begin
          gap_nxt   = GAP_W'(GAP_CYC);
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      tx_send <= 1'b0;
      tx_id   <= 1'b0;
      last_id <= 1'b1;
      gap_cnt <= '0;
      tx_en_d <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_send <= send_nxt;
      tx_id   <= id_nxt;
      last_id <= last_nxt;
      gap_cnt <= gap_nxt;
      tx_en_d <= tx_en;
      ovf     <= ovf | (sat0 & line_done0) | (sat1 & line_done1);
    end
  end

endmodule
